// File: rtl/mem_access_unit.sv
// Memory-access stage: sequences one data-memory access per request, owns the stack pointer,
// and returns the result to write-back. All memory-facing outputs come straight from flops.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// ST_IDLE  | ready for a request; fault is checked on acceptance
// ST_ACCESS| memory enable/address/data held for exactly one cycle
// ST_RESP  | response held on wb_* until write-back takes it
module mem_access_unit #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int STACK_TOP   = 255,
   parameter int STACK_LIMIT = 192
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [1:0]            req_op_i,
   input  logic [31:0]           req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   input  logic [4:0]            req_rd_i,
   output logic [31:0]           mem_address_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  sig_enable_read_o,
   output logic                  sig_enable_write_o,
   output logic                  wb_valid_o,
   input  logic                  wb_ready_i,
   output logic [DATA_WIDTH-1:0] wb_data_o,
   output logic [4:0]            wb_rd_o,
   output logic                  wb_we_o,
   output logic                  wb_fault_o,
   output logic [ADDR_WIDTH-1:0] sp_o
);

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_PUSH  = 2'b10;
   localparam logic [1:0] OP_POP   = 2'b11;

   localparam logic [ADDR_WIDTH-1:0] SP_TOP  = ADDR_WIDTH'(STACK_TOP);
   localparam logic [ADDR_WIDTH-1:0] SP_FULL = ADDR_WIDTH'(STACK_LIMIT - 1);
   localparam logic [ADDR_WIDTH-1:0] SP_ONE  = ADDR_WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   state_e                  state_q;
   logic [1:0]              op_q;
   logic [ADDR_WIDTH-1:0]   sp_q;
   logic [31:0]             mem_address_q;
   logic [DATA_WIDTH-1:0]   mem_wdata_q;
   logic                    rd_en_q;
   logic                    wr_en_q;
   logic                    wb_valid_q;
   logic [DATA_WIDTH-1:0]   wb_data_q;
   logic [4:0]              wb_rd_q;
   logic                    wb_we_q;
   logic                    wb_fault_q;

   logic                    fault_d;
   logic                    is_write_d;
   logic [ADDR_WIDTH-1:0]   acc_addr_d;

   // Fault and target address are decided from the request and the current sp at acceptance.
   always_comb begin
      fault_d    = 1'b0;
      acc_addr_d = '0;
      is_write_d = (req_op_i == OP_STORE) || (req_op_i == OP_PUSH);
      case (req_op_i)
         OP_LOAD, OP_STORE: begin
            fault_d    = |req_addr_i[31:ADDR_WIDTH];
            acc_addr_d = req_addr_i[ADDR_WIDTH-1:0];
         end
         OP_PUSH: begin
            fault_d    = (sp_q == SP_FULL);
            acc_addr_d = sp_q;
         end
         default: begin
            fault_d    = (sp_q == SP_TOP);
            acc_addr_d = sp_q + SP_ONE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_IDLE;
         op_q          <= OP_LOAD;
         sp_q          <= SP_TOP;
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
         rd_en_q       <= 1'b0;
         wr_en_q       <= 1'b0;
         wb_valid_q    <= 1'b0;
         wb_data_q     <= '0;
         wb_rd_q       <= '0;
         wb_we_q       <= 1'b0;
         wb_fault_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid_i) begin
                  op_q    <= req_op_i;
                  wb_rd_q <= req_rd_i;
                  if (fault_d) begin
                     wb_fault_q <= 1'b1;
                     wb_we_q    <= 1'b0;
                     wb_data_q  <= '0;
                     wb_valid_q <= 1'b1;
                     state_q    <= ST_RESP;
                  end else begin
                     mem_address_q <= 32'(acc_addr_d);
                     mem_wdata_q   <= is_write_d ? req_wdata_i : '0;
                     rd_en_q       <= !is_write_d;
                     wr_en_q       <= is_write_d;
                     wb_fault_q    <= 1'b0;
                     state_q       <= ST_ACCESS;
                  end
               end
            end
            ST_ACCESS: begin
               rd_en_q       <= 1'b0;
               wr_en_q       <= 1'b0;
               mem_address_q <= '0;
               mem_wdata_q   <= '0;
               wb_valid_q    <= 1'b1;
               wb_we_q       <= rd_en_q;
               wb_data_q     <= rd_en_q ? mem_rdata_i : '0;
               if (op_q == OP_PUSH) begin
                  sp_q <= sp_q - SP_ONE;
               end else if (op_q == OP_POP) begin
                  sp_q <= sp_q + SP_ONE;
               end
               state_q <= ST_RESP;
            end
            ST_RESP: begin
               if (wb_ready_i) begin
                  wb_valid_q <= 1'b0;
                  wb_data_q  <= '0;
                  wb_rd_q    <= '0;
                  wb_we_q    <= 1'b0;
                  wb_fault_q <= 1'b0;
                  state_q    <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready_o        = (state_q == ST_IDLE);
   assign mem_address_o      = mem_address_q;
   assign mem_wdata_o        = mem_wdata_q;
   assign sig_enable_read_o  = rd_en_q;
   assign sig_enable_write_o = wr_en_q;
   assign wb_valid_o         = wb_valid_q;
   assign wb_data_o          = wb_data_q;
   assign wb_rd_o            = wb_rd_q;
   assign wb_we_o            = wb_we_q;
   assign wb_fault_o         = wb_fault_q;
   assign sp_o               = sp_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage of the RISC pipeline: accepts one load/store/push/pop request per transaction from the execute stage over a valid/ready handshake, sequences the 256-word data memory's enable/address/data signals, and returns the result to write-back over a second valid/ready handshake. It owns the stack pointer and flags out-of-range addresses and stack overflow/underflow. The data memory writes level-sensitively, so every signal it receives is registered and held stable for the whole access cycle.

## Interface
- ADDR_WIDTH, 8, memory word-address width (depth 2^ADDR_WIDTH)
- DATA_WIDTH, 32, data word width
- STACK_TOP, 255, SP reset value (empty stack); full-descending stack
- STACK_LIMIT, 192, lowest word a push may write
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; one clock, reset is asynchronous and active-low
- req_valid  in  1  execute-stage request valid
- req_ready  out  1  unit can accept a request
- req_op  in  2  00 LOAD, 01 STORE, 10 PUSH, 11 POP
- req_addr  in  32  effective word address (LOAD/STORE only)
- req_wdata  in  DATA_WIDTH  store/push data
- req_rd  in  5  destination register tag
- mem_address  out  32  to data memory AddressBus
- mem_wdata  out  DATA_WIDTH  to data memory InputBus
- mem_rdata  in  DATA_WIDTH  from data memory OutputBus
- sig_enable_read  out  1  data memory read enable
- sig_enable_write  out  1  data memory write enable
- wb_valid  out  1  response valid
- wb_ready  in  1  write-back accepts response
- wb_data  out  DATA_WIDTH  loaded/popped word, 0 otherwise
- wb_rd  out  5  echoed req_rd
- wb_we  out  1  register write required (LOAD/POP without fault)
- wb_fault  out  1  request faulted, no memory side effect
- sp  out  ADDR_WIDTH  current stack pointer (next free slot)

## Operation
- FSM states IDLE, ACCESS, RESP. req_ready = (state == IDLE).
- IDLE: on req_valid, latch op/addr/wdata/rd and evaluate fault:
  - LOAD/STORE: fault if req_addr[31:ADDR_WIDTH] != 0.
  - PUSH: fault if sp < STACK_LIMIT... precisely: fault if sp == STACK_LIMIT - 1 (no room); writes go to sp while sp >= STACK_LIMIT.
  - POP: fault if sp == STACK_TOP (empty).
  - No fault -> ACCESS; fault -> RESP with wb_fault=1, wb_we=0, wb_data=0.
- ACCESS (exactly one cycle): mem_address = addr (LOAD/STORE), sp (PUSH), sp+1 (POP), zero-extended; exactly one enable high: read for LOAD/POP, write for STORE/PUSH; mem_wdata = latched wdata for writes, 0 for reads. At end of cycle: capture mem_rdata into wb_data (reads); PUSH sp <= sp-1; POP sp <= sp+1. -> RESP.
- RESP: wb_valid=1, outputs held stable until wb_ready; on handshake -> IDLE. STORE/PUSH respond with wb_we=0, wb_data=0.
- Outside ACCESS: both enables 0, mem_address=0, mem_wdata=0. Enables and bus outputs are flop outputs (no combinational glitch).
- sp arithmetic is ADDR_WIDTH-bit; fault checks guarantee no wrap.

## Timing
- Reset values: state IDLE, req_ready=1, sig_enable_read=0, sig_enable_write=0, mem_address=0, mem_wdata=0, wb_valid=0, wb_data=0, wb_rd=0, wb_we=0, wb_fault=0, sp=STACK_TOP.
- Request accepted at edge N -> ACCESS during cycle N..N+1 -> wb_valid high after edge N+1; faulted request -> wb_valid high after edge N.
- Maximum throughput: one request per 3 cycles (2 when faulted) with wb_ready held high.
- wb_ready low: stay in RESP indefinitely; no new request accepted (req_ready=0).
- req_valid while not IDLE: ignored, not latched.
- Reset asserted mid-ACCESS: enables drop asynchronously, sp restored to STACK_TOP, pending transaction discarded (no response).

## Test plan
- Reset release -> all outputs at reset values, sp=255, req_ready=1.
- STORE addr 3 data 0xDEADBEEF, then LOAD addr 3 rd 7 -> one-cycle write-enable pulse with mem_address=3; load responds wb_data=0xDEADBEEF, wb_rd=7, wb_we=1, wb_valid 2 cycles after accept.
- LOAD addr 0 on initialised memory -> wb_data=10; LOAD addr 0x100 -> wb_fault=1, no enable pulse, wb_valid 1 cycle after accept.
- PUSH 0x11, PUSH 0x22, POP, POP -> writes at 255 and 254, pops return 0x22 then 0x11, sp returns to 255; third POP -> wb_fault=1, sp unchanged.
- Push 64 words (sp 255->191) then 65th PUSH -> wb_fault=1, no write, sp stays 191.
- Hold wb_ready low 5 cycles after a LOAD -> wb_valid/wb_data stable, req_ready=0, concurrent req_valid ignored; assert reset during a STORE's ACCESS cycle -> enable falls immediately, no response issued.
